// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched
//
// Purpose:
//   Two requesters (A: operand entry, B: ALU result) share one 8-bit binary
//   to packed-BCD converter. A round-robin arbiter accepts one request at a
//   time from IDLE. The converter then runs eight shift-and-add-3 (double
//   dabble) iterations in CONV and publishes the result with a one-cycle done
//   pulse. Operands above 99 do not fit in two BCD digits; they report
//   bcd_out = 8'hFF with ovf = 1.
//
// Handshake:
//   req_a/req_b are level requests. They are sampled only in IDLE. The
//   accepted requester sees a one-cycle gnt pulse in the cycle after the
//   accept edge. Its operand is captured on that edge, so the requester may
//   change bin_x or drop req once gnt is seen. A request still high after its
//   gnt counts as a fresh request at the next IDLE edge. A request raised
//   during CONV waits until IDLE and is not lost while it stays high.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req_a      in   1  request from A
//   bin_a      in   8  binary operand from A
//   req_b      in   1  request from B
//   bin_b      in   8  binary operand from B
//   gnt_a      out  1  one-cycle accept pulse for A
//   gnt_b      out  1  one-cycle accept pulse for B
//   busy       out  1  conversion in progress
//   done       out  1  one-cycle pulse: bcd_out/ovf/done_id updated
//   done_id    out  1  owner of the completed result (0 = A, 1 = B)
//   bcd_out    out  8  {tens, ones} BCD result, or 8'hFF on overflow
//   ovf        out  1  operand exceeded 99
//   dbg_state  out  1  FSM state (0 = IDLE, 1 = CONV) for observation

module bcd_conv_sched #(
    parameter bit FIRST_A = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [7:0] bin_a,
    input  logic       req_b,
    input  logic [7:0] bin_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] bcd_out,
    output logic       ovf,
    output logic       dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [9:0]  scr_q, scr_d;       // {hundreds[1:0], tens[3:0], ones[3:0]}
    logic [7:0]  opnd_q, opnd_d;
    logic        owner_q, owner_d;
    logic        last_b_q, last_b_d; // 1: B was granted most recently
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic [7:0]  bcd_q, bcd_d;
    logic        ovf_q, ovf_d;

    // One double-dabble step: correct the tens and ones digits, then shift
    // the scratch:operand pair left by one bit. Hundreds never needs
    // correcting because it cannot exceed 2 for an 8-bit operand.
    logic [3:0]  tens_adj, ones_adj;
    logic [17:0] shifted;

    always_comb begin
        tens_adj = (scr_q[7:4] >= 4'd5) ? scr_q[7:4] + 4'd3 : scr_q[7:4];
        ones_adj = (scr_q[3:0] >= 4'd5) ? scr_q[3:0] + 4'd3 : scr_q[3:0];
        shifted  = {scr_q[8], tens_adj, ones_adj, opnd_q, 1'b0};
    end

    // With both requests high, the requester not granted last wins.
    logic any_req;
    logic win_b;

    always_comb begin
        any_req = req_a | req_b;
        win_b   = req_b & (~req_a | ~last_b_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scr_d     = scr_q;
        opnd_d    = opnd_q;
        owner_d   = owner_q;
        last_b_d  = last_b_q;
        gnt_a_d   = 1'b0;
        gnt_b_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_CONV;
                    gnt_a_d  = ~win_b;
                    gnt_b_d  = win_b;
                    busy_d   = 1'b1;
                    cnt_d    = 3'd0;
                    scr_d    = 10'd0;
                    opnd_d   = win_b ? bin_b : bin_a;
                    owner_d  = win_b;
                    last_b_d = win_b;
                end
            end
            ST_CONV: begin
                scr_d  = shifted[17:8];
                opnd_d = shifted[7:0];
                cnt_d  = cnt_q + 3'd1;
                // cnt_q == 7 marks the eighth iteration: publish the result
                // straight from the final shift.
                if (cnt_q == 3'd7) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    if (shifted[17:16] == 2'd0) begin
                        bcd_d = shifted[15:8];
                        ovf_d = 1'b0;
                    end else begin
                        bcd_d = 8'hFF;
                        ovf_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            scr_q     <= 10'd0;
            opnd_q    <= 8'd0;
            owner_q   <= 1'b0;
            // "Last granted" starts as the side that should lose the first tie.
            last_b_q  <= FIRST_A;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            bcd_q     <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scr_q     <= scr_d;
            opnd_q    <= opnd_d;
            owner_q   <= owner_d;
            last_b_q  <= last_b_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter: FIRST_A, default 1, meaning requester A holds priority for the first arbitration after reset (0 gives B priority).
REQ-002 The clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req_a  input  1  level request from requester A (operand-entry path).
REQ-006 Port: bin_a  input  8  unsigned binary operand from A.
REQ-007 Port: req_b  input  1  level request from requester B (ALU-result path).
REQ-008 Port: bin_b  input  8  unsigned binary operand from B.
REQ-009 Port: gnt_a  output  1  one-cycle pulse: A's request was accepted.
REQ-010 Port: gnt_b  output  1  one-cycle pulse: B's request was accepted.
REQ-011 Port: busy  output  1  conversion in progress.
REQ-012 Port: done  output  1  one-cycle pulse: bcd_out/ovf/done_id updated.
REQ-013 Port: done_id  output  1  owner of the completed result (0 = A, 1 = B).
REQ-014 Port: bcd_out  output  8  packed BCD result, tens in [7:4], ones in [3:0].
REQ-015 Port: ovf  output  1  operand exceeded 99.

Function
REQ-016 The block SHALL be a two-state FSM: IDLE and CONV, with a 3-bit iteration counter.
REQ-017 Requests SHALL be sampled only in IDLE; requests asserted during CONV are held off, not lost, provided the requester keeps req high.
REQ-018 On the IDLE edge where either req is high, the block SHALL latch the winner's operand, set the winner's gnt for exactly one cycle, set busy, clear the counter, and enter CONV.
REQ-019 Arbitration: a single requester wins outright; with both high, the requester not granted last SHALL win (round-robin); after reset, "last granted" SHALL be B if FIRST_A=1 and A otherwise.
REQ-020 The operand SHALL be captured at the accept edge; later changes on bin_a/bin_b SHALL NOT affect the result.
REQ-021 CONV SHALL run exactly 8 shift-and-add-3 iterations, one per edge, on a 10-bit BCD scratch (hundreds[1:0], tens[3:0], ones[3:0]): any tens or ones digit >= 5 gets +3, then the scratch:operand pair shifts left one bit, MSB first.
REQ-022 On the 8th CONV edge the block SHALL load the outputs. If hundreds = 0: bcd_out = {tens, ones} and ovf = 0. Otherwise: bcd_out = 8'hFF and ovf = 1.
REQ-023 On that same 8th edge, done_id SHALL be set to the owner, done SHALL pulse for one cycle, busy SHALL drop, and the FSM SHALL return to IDLE.
REQ-024 Latency: accept at edge N gives done high in the cycle following edge N+8; the earliest next accept is edge N+9.
REQ-025 bcd_out, ovf and done_id SHALL hold their values until the next done; gnt_a and gnt_b SHALL never be high together.
REQ-026 A requester still holding req after its gnt SHALL be treated as a new request at the next IDLE edge.

Reset
REQ-027 While rst_n = 0 (asynchronously, including mid-conversion): state = IDLE, counter = 0, scratch = 0, gnt_a = gnt_b = busy = done = done_id = ovf = 0, bcd_out = 8'h00, last-granted per REQ-019.
REQ-028 An aborted conversion SHALL produce no done, and its owner SHALL NOT be considered granted.

Verification
REQ-029 Reset, no requests -> all outputs 0, busy 0 indefinitely.
REQ-030 req_a = 1, bin_a = 57 -> gnt_a one cycle after accept edge; done 8 cycles later; bcd_out = 8'h57, ovf = 0, done_id = 0.
REQ-031 Operand sweep via A (0, 9, 10, 99, 100, 255) -> bcd_out 8'h00, 8'h09, 8'h10, 8'h99, 8'hFF, 8'hFF; ovf 0, 0, 0, 0, 1, 1.
REQ-032 req_a and req_b held together, bin_a = 12, bin_b = 34, FIRST_A = 1 -> A converts first (8'h12, id 0), then B accepted at edge N+9 (8'h34, id 1), then alternating while both are held.
REQ-033 req_b raised during A's CONV -> no gnt_b until IDLE; gnt_b on edge N+9; bin_b changed after gnt_b does not alter the result.
REQ-034 rst_n pulsed low during iteration 4 -> outputs 0 immediately, no done; after release, bin_a = 42 converts to 8'h42 with the standard latency.
